framebuffer_sp: RTL and testbench

Single-clock, parametrised successor to the dual-clock framebuffer. Stores a HEIGHT x WIDTH image at BPP bits/pixel in inferred block RAM. Accepts multi-pixel masked writes over a valid/ready handshake and serves single-pixel reads through a fixed 2-cycle pipeline. Sits between the drawing engine (write side) and the video timing/scan-out logic (read side); an optional hardware clear engine fills the whole buffer with one colour.

---
 rtl/framebuffer_sp_if.sv | 42 ++++
 rtl/framebuffer_sp.sv | 157 +++++++++++++++
 tb/tb_framebuffer_sp.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_sp_if.sv
// Write, read and clear signal bundle for framebuffer_sp.
// The master side is the client (drawing engine / scan-out); the slave side is the framebuffer.
interface framebuffer_sp_if #(
    parameter int HEIGHT   = 512,
    parameter int WIDTH    = 1024,
    parameter int WIDTH_IN = 4,
    parameter int BPP      = 1
);
    localparam int YW = $clog2(HEIGHT);
    localparam int XW = $clog2(WIDTH);

    logic                    in_valid;
    logic                    in_ready;
    logic [YW-1:0]           in_y;
    logic [XW-1:0]           in_x;
    logic [WIDTH_IN*BPP-1:0] in_data;
    logic [WIDTH_IN-1:0]     in_mask;

    logic                    out_req;
    logic [YW-1:0]           out_y;
    logic [XW-1:0]           out_x;
    logic                    out_valid;
    logic [BPP-1:0]          out_data;

    logic                    clear_start;
    logic [BPP-1:0]          clear_value;
    logic                    clear_busy;

    modport master (
        output in_valid, in_y, in_x, in_data, in_mask,
        output out_req, out_y, out_x,
        output clear_start, clear_value,
        input  in_ready, out_valid, out_data, clear_busy
    );

    modport slave (
        input  in_valid, in_y, in_x, in_data, in_mask,
        input  out_req, out_y, out_x,
        input  clear_start, clear_value,
        output in_ready, out_valid, out_data, clear_busy
    );
endinterface

// File: rtl/framebuffer_sp.sv
// Single-clock HEIGHT x WIDTH framebuffer: masked multi-pixel writes, 2-cycle pixel reads.
// Define FRAMEBUFFER_CLEAR_EN to build the whole-buffer hardware clear engine.
module framebuffer_sp #(
    parameter int HEIGHT   = 512,
    parameter int WIDTH    = 1024,
    parameter int WIDTH_IN = 4,
    parameter int BPP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    framebuffer_sp_if.slave  bus
);
    localparam int YW     = $clog2(HEIGHT);
    localparam int XW     = $clog2(WIDTH);
    localparam int SW     = $clog2(WIDTH_IN);
    localparam int DEPTH  = HEIGHT * WIDTH / WIDTH_IN;
    localparam int AW     = $clog2(DEPTH);
    localparam int WORD_W = WIDTH_IN * BPP;

    function automatic logic [BPP-1:0] pick_pixel(input logic [WORD_W-1:0] word,
                                                  input logic [XW-1:0]     sel);
        logic [BPP-1:0] px;
        px = '0;
        for (int k = 0; k < WIDTH_IN; k++) begin
            if (sel == XW'(k)) px = word[k*BPP +: BPP];
        end
        return px;
    endfunction

    logic [YW+XW-1:0]  wr_pix;
    logic [YW+XW-1:0]  rd_pix;
    logic [AW-1:0]     in_addr;
    logic [AW-1:0]     rd_addr_p0;

    // Word address is the pixel address with the in-word pixel index dropped.
    assign wr_pix     = {bus.in_y, bus.in_x};
    assign rd_pix     = {bus.out_y, bus.out_x};
    assign in_addr    = AW'(wr_pix >> SW);
    assign rd_addr_p0 = AW'(rd_pix >> SW);

    logic              clearing;
    logic [AW-1:0]     clr_addr;
    logic [WORD_W-1:0] clr_word;

`ifdef FRAMEBUFFER_CLEAR_EN
    typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [BPP-1:0] clr_val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.clear_start) clr_val_q <= bus.clear_value;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) state_d = S_IDLE;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign clearing       = (state_q == S_CLEAR);
    assign clr_addr       = cnt_q;
    assign clr_word       = {WIDTH_IN{clr_val_q}};
    assign bus.clear_busy = clearing;
    assign bus.in_ready   = !rst && !clearing;
`else
    logic unused_clear;

    assign unused_clear   = ^{bus.clear_start, bus.clear_value};
    assign clearing       = 1'b0;
    assign clr_addr       = '0;
    assign clr_word       = '0;
    assign bus.clear_busy = 1'b0;
    assign bus.in_ready   = !rst;
`endif

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [WIDTH_IN-1:0] wr_mask;

    // The clear engine owns the write port; a reset cycle suppresses its write.
    always_comb begin
        wr_en   = bus.in_valid && bus.in_ready;
        wr_addr = in_addr;
        wr_data = bus.in_data;
        wr_mask = bus.in_mask;
        if (clearing) begin
            wr_en   = !rst;
            wr_addr = clr_addr;
            wr_data = clr_word;
            wr_mask = '1;
        end
    end

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_word_p1;
    logic [XW-1:0]     sel_p1;
    logic              vld_p1;
    logic              vld_p2;
    logic [BPP-1:0]    out_data_p2;

    // Stage 0 -> 1: registered RAM read; NBA ordering gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < WIDTH_IN; k++) begin
                if (wr_mask[k]) mem[wr_addr][k*BPP +: BPP] <= wr_data[k*BPP +: BPP];
            end
        end
        if (bus.out_req) begin
            rd_word_p1 <= mem[rd_addr_p0];
            sel_p1     <= bus.out_x & XW'(WIDTH_IN - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= bus.out_req;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1 -> 2: pixel select; output holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst)         out_data_p2 <= '0;
        else if (vld_p1) out_data_p2 <= pick_pixel(rd_word_p1, sel_p1);
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_data  = out_data_p2;
endmodule

// File: tb/tb_framebuffer_sp.sv
// Directed bench for framebuffer_sp (4 x 8 image, 4 pixels/word, 2 bits/pixel) with a read scoreboard.
module tb_framebuffer_sp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    framebuffer_sp_if #(.HEIGHT(4), .WIDTH(8), .WIDTH_IN(4), .BPP(2)) fb ();

    framebuffer_sp #(.HEIGHT(4), .WIDTH(8), .WIDTH_IN(4), .BPP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (fb)
    );

    typedef struct {
        logic [1:0] d;
        int         due;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pops one expectation; latency is checked against its due cycle.
    always @(negedge clk) begin
        if (fb.out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rd_unexpected: got out_valid=1 data=%0h, expected no output", fb.out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_data"}, 32'(fb.out_data), 32'(e.d));
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s_missing: got no out_valid by cycle %0d, expected data %0h", e.name, e.due, e.d);
        end
    end

    task automatic drive_idle();
        fb.in_valid    = 1'b0;
        fb.in_y        = '0;
        fb.in_x        = '0;
        fb.in_data     = '0;
        fb.in_mask     = '0;
        fb.out_req     = 1'b0;
        fb.out_y       = '0;
        fb.out_x       = '0;
        fb.clear_start = 1'b0;
        fb.clear_value = '0;
    endtask

    task automatic wr(input logic [1:0] y, input logic [2:0] x, input logic [7:0] d, input logic [3:0] m);
        bit done;
        done       = 1'b0;
        fb.in_valid = 1'b1;
        fb.in_y     = y;
        fb.in_x     = x;
        fb.in_data  = d;
        fb.in_mask  = m;
        for (int t = 0; t < 50 && !done; t++) begin
            if (fb.in_ready) done = 1'b1;
            @(negedge clk);
        end
        fb.in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL wr_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic rd(input string name, input logic [1:0] y, input logic [2:0] x, input logic [1:0] exp);
        exp_t e;
        fb.out_req = 1'b1;
        fb.out_y   = y;
        fb.out_x   = x;
        e.d    = exp;
        e.due  = cyc + 2;
        e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        fb.out_req = 1'b0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(fb.in_ready), 32'd0);
        chk("rst_out_valid", 32'(fb.out_valid), 32'd0);
        chk("rst_out_data", 32'(fb.out_data), 32'd0);
        chk("rst_clear_busy", 32'(fb.clear_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(fb.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(fb.out_valid), 32'd0);
        chk("post_rst_clear_busy", 32'(fb.clear_busy), 32'd0);

        // Contents are undefined after power-up: zero every word first.
        for (int y = 0; y < 4; y++) begin
            for (int xw = 0; xw < 2; xw++) wr(2'(y), 3'(xw * 4), 8'h00, 4'hF);
        end

        // 8'hE4 = pixels 0,1,2,3 from bit 0 upward.
        wr(2'd3, 3'd0, 8'hE4, 4'hF);
        rd("full_x0", 2'd3, 3'd0, 2'd0);
        rd("full_x1", 2'd3, 3'd1, 2'd1);
        rd("full_x2", 2'd3, 3'd2, 2'd2);
        rd("full_x3", 2'd3, 3'd3, 2'd3);

        // Preload 3s, then clear pixels 0 and 2 only.
        wr(2'd1, 3'd4, 8'hFF, 4'hF);
        wr(2'd1, 3'd4, 8'h00, 4'b0101);
        rd("mask_x4", 2'd1, 3'd4, 2'd0);
        rd("mask_x5", 2'd1, 3'd5, 2'd3);
        rd("mask_x6", 2'd1, 3'd6, 2'd0);
        rd("mask_x7", 2'd1, 3'd7, 2'd3);

        // Low x bits of a write are ignored: x=6 targets the word starting at x=4.
        wr(2'd2, 3'd6, 8'h1B, 4'hF);
        rd("xlow_x5", 2'd2, 3'd5, 2'd2);
        rd("xlow_x7", 2'd2, 3'd7, 2'd0);

        wr(2'd3, 3'd0, 8'hFF, 4'h0);
        rd("mask0_noop", 2'd3, 3'd2, 2'd2);

        // Same-cycle read and write of word 0: read sees old data, next read sees new.
        fb.in_valid = 1'b1;
        fb.in_y     = 2'd0;
        fb.in_x     = 3'd0;
        fb.in_data  = 8'h55;
        fb.in_mask  = 4'hF;
        rd("rbw_old", 2'd0, 3'd1, 2'd0);
        fb.in_valid = 1'b0;
        rd("rbw_new", 2'd0, 3'd1, 2'd1);

        // Last word, back-to-back reads: 8'h9C = pixels 0,3,1,2.
        wr(2'd3, 3'd7, 8'h9C, 4'hF);
        rd("last_x4", 2'd3, 3'd4, 2'd0);
        rd("last_x5", 2'd3, 3'd5, 2'd3);
        rd("last_x6", 2'd3, 3'd6, 2'd1);
        rd("last_x7", 2'd3, 3'd7, 2'd2);
        repeat (4) @(negedge clk);
        chk("hold_out_valid", 32'(fb.out_valid), 32'd0);
        chk("hold_out_data", 32'(fb.out_data), 32'd2);

`ifdef FRAMEBUFFER_CLEAR_EN
        // Clear to 1 while a write to y=0,x=4 waits behind it.
        fb.clear_start = 1'b1;
        fb.clear_value = 2'd1;
        @(negedge clk);
        fb.clear_start = 1'b0;
        fb.in_valid    = 1'b1;
        fb.in_y        = 2'd0;
        fb.in_x        = 3'd4;
        fb.in_data     = 8'hE4;
        fb.in_mask     = 4'hF;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("clr_busy_%0d", i), 32'(fb.clear_busy), 32'd1);
            chk($sformatf("clr_in_ready_%0d", i), 32'(fb.in_ready), 32'd0);
            @(negedge clk);
        end
        chk("clr_done_busy", 32'(fb.clear_busy), 32'd0);
        chk("clr_done_in_ready", 32'(fb.in_ready), 32'd1);
        @(negedge clk);
        fb.in_valid = 1'b0;
        rd("held_x4", 2'd0, 3'd4, 2'd0);
        rd("held_x5", 2'd0, 3'd5, 2'd1);
        rd("held_x6", 2'd0, 3'd6, 2'd2);
        rd("held_x7", 2'd0, 3'd7, 2'd3);
        rd("clr_y0x0", 2'd0, 3'd0, 2'd1);
        rd("clr_y1x5", 2'd1, 3'd5, 2'd1);
        rd("clr_y3x7", 2'd3, 3'd7, 2'd1);
        repeat (3) @(negedge clk);

        // Reset after three clear writes (words 0..2) leaves word 3 onward untouched.
        fb.clear_start = 1'b1;
        fb.clear_value = 2'd2;
        @(negedge clk);
        fb.clear_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstclr_busy", 32'(fb.clear_busy), 32'd0);
        rst = 1'b0;
        chk("rstclr_in_ready", 32'(fb.in_ready), 32'd1);
        @(negedge clk);
        chk("rstclr_busy_after", 32'(fb.clear_busy), 32'd0);
        rd("rstclr_w0", 2'd0, 3'd2, 2'd2);
        rd("rstclr_w1", 2'd0, 3'd5, 2'd2);
        rd("rstclr_w2", 2'd1, 3'd2, 2'd2);
        rd("rstclr_w3", 2'd1, 3'd4, 2'd1);
        rd("rstclr_w7", 2'd3, 3'd7, 2'd1);
`else
        // Without the clear engine a clear request changes nothing.
        fb.clear_start = 1'b1;
        fb.clear_value = 2'd3;
        @(negedge clk);
        fb.clear_start = 1'b0;
        chk("noclr_busy", 32'(fb.clear_busy), 32'd0);
        chk("noclr_in_ready", 32'(fb.in_ready), 32'd1);
        @(negedge clk);
        chk("noclr_busy_later", 32'(fb.clear_busy), 32'd0);
        rd("noclr_data", 2'd3, 3'd5, 2'd3);
        rd("noclr_data2", 2'd0, 3'd0, 2'd1);
`endif

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
